sequence_player: RTL
====================

Name: sequence_player

Overview:
- Playback engine for the Genius game. Sits directly downstream of the level-selected rate mux and consumes its CLKHZ output.
- On start, it shows the current round's colour sequence on the four LEDs. Each colour is lit for one CLKHZ period, followed by one blank CLKHZ period.
- Colours come from a reseedable 8-bit LFSR, so every round replays the same prefix of the sequence.
- Exposes the colour currently shown and its step index so the input checker can compare against them.

Parameters:
- MAX_ROUND, 15, maximum sequence length. round is 4 bits wide.
- SEED, 8'hA5, reset and fallback seed. Must be nonzero.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- CLKHZ  in  1  level-selected slow rate from the mux; sampled in the clock domain
- start  in  1  one-cycle request to play a round; honoured in IDLE only
- round  in  4  number of steps to play (1..15); 0 is treated as 1; latched on start
- new_seed  in  1  in IDLE, capture a new seed from the free-running LFSR
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse when playback completes
- led  out  4  one-hot lit colour; 0000 when blank
- step_color  out  2  colour index of the current step
- step_idx  out  4  index of the current step (0-based)

Behaviour:
- Clocking and reset:
  - All state is updated on the clock rising edge.
  - Reset is synchronous and overrides everything, including mid-playback.
  - Reset values: state=IDLE, busy=0, done=0, led=0000, step_color=0, step_idx=0, CLKHZ_q=0, seed_reg=SEED, free_lfsr=SEED, play_lfsr=SEED.
- Tick detection:
  - tick = CLKHZ & ~CLKHZ_q, where CLKHZ_q is CLKHZ registered every clock.
  - If CLKHZ is high when reset releases, a tick is detected on the first cycle. This is accepted behaviour.
  - Level changes mid-play only change tick spacing; no special handling.
- LFSR rule, shared by free_lfsr and play_lfsr:
  - Shift left, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Colour = play_lfsr[1:0].
  - One-hot mapping: colour 0→0001, 1→0010, 2→0100, 3→1000.
- Free-running LFSR and seed capture:
  - free_lfsr advances every clock in all states.
  - IDLE with new_seed=1: seed_reg <= free_lfsr, or SEED if free_lfsr is 0.
  - new_seed is ignored outside IDLE.
- IDLE:
  - busy=0, led=0000.
  - start=1: latch rlen = (round==0 ? 1 : round), load play_lfsr <= seed_reg, set step_idx=0, go to ALIGN.
  - If start and new_seed are both high, the seed update and the start take effect on the same edge. Playback uses the OLD seed_reg.
- ALIGN:
  - busy=1, led=0000. Waits for the first tick so every lit phase is one full period.
  - tick → go to ON.
- ON:
  - led = onehot(play_lfsr[1:0]), step_color = play_lfsr[1:0].
  - tick → go to OFF.
- OFF:
  - led=0000.
  - tick with step_idx == rlen-1 → go to DONE.
  - tick otherwise → step_idx+1, advance play_lfsr once, go to ON.
- DONE:
  - busy=1, done=1 for exactly one cycle, then go to IDLE.
- Held outputs:
  - step_idx and step_color hold their last values in IDLE until the next start.
- Handshake:
  - start while busy=1 is dropped; it is not queued.
  - A new start is accepted no earlier than the cycle after done.
- Latency:
  - start → busy=1 on the next edge.
  - First led lights on the first tick after ALIGN is entered.
  - Total length is rlen lit periods plus rlen blank periods, plus the alignment wait.
- Replay:
  - Each start reloads from seed_reg, so round N+1 repeats the first N colours of round N, then adds one.

Test Plan:
1. Reset then round=3, start, CLKHZ toggling every 4 clocks → led sequence 0010, 0000, 0100, 0000, 0010, 0000 (LFSR values A5, 4A, 95). step_idx goes 0, 1, 2. done pulses once. busy then falls.
2. round=0, start → exactly one lit phase (0010) then done. round=15 → 15 lit phases, step_idx ends at 14.
3. start pulsed again while busy, mid-ON → ignored; sequence and step_idx are unchanged, and done occurs only once.
4. Play round=2 then round=3 with no new_seed → the first two colours are identical across both rounds. Then new_seed in IDLE → seed_reg changes and differs from A5.
5. Assert reset during the second ON phase → on the next edge state=IDLE, led=0000, busy=0, done=0, seed_reg=A5. No done pulse is produced.
6. start and new_seed in the same IDLE cycle → playback begins with colour 01 (old seed A5). Also: CLKHZ held high at reset release → a single spurious tick causes no lit phase while IDLE.

Source files
------------

// File: rtl/sequence_player.sv
// Genius game playback engine: shows the current round's colour sequence on
// four LEDs, one CLKHZ period lit and one period blank per step. Colours come
// from an 8-bit LFSR reloaded from a captured seed, so each round replays the
// previous round's prefix.
module sequence_player #(
  parameter int          MAX_ROUND = 15,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       CLKHZ,
  input  logic       start,
  input  logic [3:0] round,
  input  logic       new_seed,
  output logic       busy,
  output logic       done,
  output logic [3:0] led,
  output logic [1:0] step_color,
  output logic [3:0] step_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       clkhz_q;
  logic [7:0] seed_q;
  logic [7:0] free_q;
  logic [7:0] play_q;
  logic [3:0] rlen_q;
  logic [3:0] idx_q;
  logic [1:0] color_q;
  logic [3:0] led_q;
  logic       busy_q;
  logic       done_q;

  logic       tick;
  logic [7:0] free_d;
  logic [7:0] play_d;
  logic [3:0] rlen_d;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // Rising edge of the slow rate marks one period boundary.
  assign tick   = CLKHZ & ~clkhz_q;
  assign free_d = lfsr_next(free_q);
  assign play_d = lfsr_next(play_q);

  // Round length: zero plays a single step, oversize rounds are clamped.
  always_comb begin
    rlen_d = round;
    if (round == 4'd0) begin
      rlen_d = 4'd1;
    end else if (int'(round) > MAX_ROUND) begin
      rlen_d = 4'(MAX_ROUND);
    end
  end

  // Playback FSM with registered outputs, free-running LFSR and seed capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      clkhz_q <= 1'b0;
      seed_q  <= SEED;
      free_q  <= SEED;
      play_q  <= SEED;
      rlen_q  <= 4'd1;
      idx_q   <= 4'd0;
      color_q <= 2'd0;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clkhz_q <= CLKHZ;
      free_q  <= free_d;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          led_q  <= 4'b0000;
          if (new_seed) begin
            // An all-zero LFSR would lock up, so fall back to the default seed.
            seed_q <= (free_q == 8'd0) ? SEED : free_q;
          end
          if (start) begin
            // Playback uses the seed held before any same-cycle capture.
            rlen_q  <= rlen_d;
            play_q  <= seed_q;
            idx_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          // Wait for a period boundary so the first lit phase is a full period.
          if (tick) begin
            led_q   <= onehot(play_q[1:0]);
            color_q <= play_q[1:0];
            state_q <= S_ON;
          end
        end
        S_ON: begin
          if (tick) begin
            led_q   <= 4'b0000;
            state_q <= S_OFF;
          end
        end
        S_OFF: begin
          if (tick) begin
            if (idx_q == rlen_q - 4'd1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              play_q  <= play_d;
              led_q   <= onehot(play_d[1:0]);
              color_q <= play_d[1:0];
              state_q <= S_ON;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          led_q   <= 4'b0000;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign led        = led_q;
  assign step_color = color_q;
  assign step_idx   = idx_q;

endmodule
